// File: rtl/fm_tile_sched_if.sv
// Handshake bundle between the tile scheduler, the input read-master controller
// and the compute side.
interface fm_tile_sched_if #(
    parameter int CW = 16
);
    logic          start;
    logic          load_start;
    logic          load_done;
    logic [CW-1:0] tile_base_m;
    logic [CW-1:0] tile_base_row;
    logic [CW-1:0] tile_base_col;
    logic          tile_ready;
    logic          tile_consumed;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        input  start,
        input  load_done,
        input  tile_consumed,
        output load_start,
        output tile_base_m,
        output tile_base_row,
        output tile_base_col,
        output tile_ready,
        output busy,
        output done,
        output err
    );

    modport slave (
        output start,
        output load_done,
        output tile_consumed,
        input  load_start,
        input  tile_base_m,
        input  tile_base_row,
        input  tile_base_col,
        input  tile_ready,
        input  busy,
        input  done,
        input  err
    );
endinterface

// File: rtl/fm_tile_sched.sv
// Layer-level tile scheduler: walks tile origins over the M x R x C input map
// and issues one load per tile, throttled by free tile-buffer credits.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | layer not running; bases/credits held at their start values
// ST_ISSUE     | waiting for a free buffer credit to issue the current tile
// ST_WAIT_LOAD | load requested; waiting for load_done from the read master
// ST_ADVANCE   | tile landed; step to next origin or finish the walk
// ST_DRAIN     | all tiles loaded; waiting for compute to free every buffer
module fm_tile_sched #(
    parameter int CW   = 16,
    parameter int M    = 32,
    parameter int R    = 64,
    parameter int C    = 32,
    parameter int Tm   = 16,
    parameter int Tr   = 64,
    parameter int Tc   = 16,
    parameter int NBUF = 2
) (
    input  logic            clk,
    input  logic            rst,
    fm_tile_sched_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_LOAD = 3'd2,
        ST_ADVANCE   = 3'd3,
        ST_DRAIN     = 3'd4
    } state_t;

    localparam logic [2:0]    CRED_FULL = 3'(NBUF);
    localparam logic [CW-1:0] M_LAST    = CW'(M - Tm);
    localparam logic [CW-1:0] R_LAST    = CW'(R - Tr);
    localparam logic [CW-1:0] C_LAST    = CW'(C - Tc);
    localparam logic [CW-1:0] M_STEP    = CW'(Tm);
    localparam logic [CW-1:0] R_STEP    = CW'(Tr);
    localparam logic [CW-1:0] C_STEP    = CW'(Tc);

    state_t        state_q, state_d;
    logic [CW-1:0] base_m_q, base_m_d;
    logic [CW-1:0] base_row_q, base_row_d;
    logic [CW-1:0] base_col_q, base_col_d;
    logic [2:0]    credits_q, credits_d;
    logic          load_start_q, load_start_d;
    logic          tile_ready_q, tile_ready_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          issue;
    logic          consume;
    logic          last_tile;

    assign last_tile = (base_m_q == M_LAST) && (base_row_q == R_LAST) &&
                       (base_col_q == C_LAST);

    always_comb begin
        state_d      = state_q;
        base_m_d     = base_m_q;
        base_row_d   = base_row_q;
        base_col_d   = base_col_q;
        credits_d    = credits_q;
        load_start_d = 1'b0;
        tile_ready_d = 1'b0;
        done_d       = 1'b0;
        err_d        = err_q;
        issue        = 1'b0;
        consume      = bus.tile_consumed && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                base_m_d   = '0;
                base_row_d = '0;
                base_col_d = '0;
                if (bus.start) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (credits_q != 3'd0) begin
                    issue        = 1'b1;
                    load_start_d = 1'b1;
                    state_d      = ST_WAIT_LOAD;
                end
            end
            ST_WAIT_LOAD: begin
                if (bus.load_done) begin
                    tile_ready_d = 1'b1;
                    state_d      = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                if (last_tile) begin
                    state_d = ST_DRAIN;
                end else begin
                    // Column is the innermost loop, channel the outermost.
                    if (base_col_q == C_LAST) begin
                        base_col_d = '0;
                        if (base_row_q == R_LAST) begin
                            base_row_d = '0;
                            base_m_d   = base_m_q + M_STEP;
                        end else begin
                            base_row_d = base_row_q + R_STEP;
                        end
                    end else begin
                        base_col_d = base_col_q + C_STEP;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (credits_q == CRED_FULL) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An extra consume with every buffer already free is dropped and flagged.
        if (state_q == ST_IDLE) begin
            credits_d = CRED_FULL;
        end else if (issue && !consume) begin
            credits_d = credits_q - 3'd1;
        end else if (consume && !issue) begin
            if (credits_q == CRED_FULL) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            base_m_q     <= '0;
            base_row_q   <= '0;
            base_col_q   <= '0;
            credits_q    <= CRED_FULL;
            load_start_q <= 1'b0;
            tile_ready_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_m_q     <= base_m_d;
            base_row_q   <= base_row_d;
            base_col_q   <= base_col_d;
            credits_q    <= credits_d;
            load_start_q <= load_start_d;
            tile_ready_q <= tile_ready_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.load_start    = load_start_q;
    assign bus.tile_ready    = tile_ready_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.tile_base_m   = base_m_q;
    assign bus.tile_base_row = base_row_q;
    assign bus.tile_base_col = base_col_q;

endmodule

// File: tb/tb_fm_tile_sched.sv
// Directed bench for fm_tile_sched: full layer walk, credit throttling,
// overflow, mid-run reset and ignored inputs.
module tb_fm_tile_sched;

    localparam int CW = 16;
    localparam logic [63:0] S_IDLE  = 64'd0;
    localparam logic [63:0] S_ISSUE = 64'd1;
    localparam logic [63:0] S_WAIT  = 64'd2;
    localparam logic [63:0] S_DRAIN = 64'd4;

    logic clk;
    logic rst;
    logic start_drv;
    logic main_ld;
    logic main_tc;
    logic auto_ld_en;
    logic auto_tc_en;
    logic auto_ld_p;
    logic auto_tc_p;
    int   cyc;

    int          n_chk;
    int          n_fail;
    int          ls_count;
    int          rdy_count;
    int          done_count;
    int          done_cyc;
    int          start_cyc;
    logic        done_busy;
    logic [47:0] ls_base [8];
    int          ls_cyc [8];

    fm_tile_sched_if #(.CW(CW)) bus ();

    assign bus.start         = start_drv;
    assign bus.load_done     = main_ld | auto_ld_p;
    assign bus.tile_consumed = main_tc | auto_tc_p;

    fm_tile_sched #(
        .CW(CW), .M(32), .R(64), .C(32), .Tm(16), .Tr(64), .Tc(16), .NBUF(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Read master answers 5 cycles after load_start; compute frees 3 after tile_ready.
    initial begin
        int ld_t;
        int tc_t;
        ld_t = 0;
        tc_t = 0;
        auto_ld_p = 1'b0;
        auto_tc_p = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            auto_ld_p = 1'b0;
            auto_tc_p = 1'b0;
            if (!auto_ld_en) begin
                ld_t = 0;
            end else begin
                if (ld_t > 0) begin
                    ld_t = ld_t - 1;
                    if (ld_t == 0) auto_ld_p = 1'b1;
                end
                if (bus.load_start) ld_t = 5;
            end
            if (!auto_tc_en) begin
                tc_t = 0;
            end else begin
                if (tc_t > 0) begin
                    tc_t = tc_t - 1;
                    if (tc_t == 0) auto_tc_p = 1'b1;
                end
                if (bus.tile_ready) tc_t = 3;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        if (bus.load_start) begin
            if (ls_count < 8) begin
                ls_base[ls_count] = {bus.tile_base_m, bus.tile_base_row, bus.tile_base_col};
                ls_cyc[ls_count]  = cyc;
            end
            ls_count = ls_count + 1;
        end
        if (bus.tile_ready) rdy_count = rdy_count + 1;
        if (bus.done) begin
            done_count = done_count + 1;
            done_cyc   = cyc;
            done_busy  = bus.busy;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr();
        ls_count   = 0;
        rdy_count  = 0;
        done_count = 0;
        done_cyc   = 0;
        done_busy  = 1'b1;
    endtask

    task automatic pulse_start();
        start_cyc = cyc;
        start_drv = 1'b1;
        tick();
        start_drv = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [63:0] bases();
        return 64'({bus.tile_base_m, bus.tile_base_row, bus.tile_base_col});
    endfunction

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        start_drv  = 1'b0;
        main_ld    = 1'b0;
        main_tc    = 1'b0;
        auto_ld_en = 1'b0;
        auto_tc_en = 1'b0;
        clr();

        // Reset values
        run(3);
        chk("rst_load_start", 64'(bus.load_start), 64'd0);
        chk("rst_tile_ready", 64'(bus.tile_ready), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_bases", bases(), 64'd0);
        chk("rst_credits", 64'(dut.credits_q), 64'd2);
        rst = 1'b0;
        tick();

        // Spurious load_done in IDLE and ISSUE, start while busy
        clr();
        main_ld = 1'b1;
        tick();
        main_ld = 1'b0;
        chk("sp_idle_state", 64'(dut.state_q), S_IDLE);
        chk("sp_idle_busy", 64'(bus.busy), 64'd0);
        chk("sp_idle_ready", 64'(bus.tile_ready), 64'd0);
        pulse_start();
        chk("sp_issue_state", 64'(dut.state_q), S_ISSUE);
        main_ld = 1'b1;
        tick();
        main_ld = 1'b0;
        chk("sp_ls1", 64'(bus.load_start), 64'd1);
        chk("sp_wait_state", 64'(dut.state_q), S_WAIT);
        start_drv = 1'b1;
        tick();
        start_drv = 1'b0;
        chk("sp_no_ready", 64'(bus.tile_ready), 64'd0);
        chk("sp_no_ls", 64'(bus.load_start), 64'd0);
        tick();
        chk("sp_still_wait", 64'(dut.state_q), S_WAIT);
        chk("sp_bases", bases(), 64'd0);
        chk("sp_ls_count", 64'(ls_count), 64'd1);
        chk("sp_rdy_count", 64'(rdy_count), 64'd0);
        pulse_rst();

        // Default full run
        clr();
        auto_ld_en = 1'b1;
        auto_tc_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 120 && done_count == 0; i++) tick();
        chk("full_done_seen", 64'(done_count), 64'd1);
        run(4);
        auto_ld_en = 1'b0;
        auto_tc_en = 1'b0;
        chk("full_ls_count", 64'(ls_count), 64'd4);
        chk("full_rdy_count", 64'(rdy_count), 64'd4);
        chk("full_base0", 64'(ls_base[0]), 64'({16'd0, 16'd0, 16'd0}));
        chk("full_base1", 64'(ls_base[1]), 64'({16'd0, 16'd0, 16'd16}));
        chk("full_base2", 64'(ls_base[2]), 64'({16'd16, 16'd0, 16'd0}));
        chk("full_base3", 64'(ls_base[3]), 64'({16'd16, 16'd0, 16'd16}));
        chk("full_start_lat", 64'(ls_cyc[0] - start_cyc), 64'd2);
        chk("full_tile_gap", 64'(ls_cyc[1] - ls_cyc[0]), 64'd8);
        chk("full_done_lat", 64'(done_cyc - start_cyc), 64'd37);
        chk("full_done_count", 64'(done_count), 64'd1);
        chk("full_done_busy", 64'(done_busy), 64'd0);
        chk("full_err", 64'(bus.err), 64'd0);
        chk("full_idle", 64'(dut.state_q), S_IDLE);

        // Credit throttle: no consumes, two loads then stall in ISSUE
        clr();
        auto_ld_en = 1'b1;
        pulse_start();
        run(30);
        chk("thr_ls_count", 64'(ls_count), 64'd2);
        chk("thr_state", 64'(dut.state_q), S_ISSUE);
        chk("thr_credits", 64'(dut.credits_q), 64'd0);
        main_tc = 1'b1;
        tick();
        main_tc = 1'b0;
        chk("thr_ls_early", 64'(bus.load_start), 64'd0);
        tick();
        chk("thr_ls_third", 64'(bus.load_start), 64'd1);
        chk("thr_base_third", bases(), 64'({16'd16, 16'd0, 16'd0}));
        run(10);
        chk("thr_stall2_state", 64'(dut.state_q), S_ISSUE);
        chk("thr_stall2_credits", 64'(dut.credits_q), 64'd0);
        chk("thr_stall2_ls", 64'(ls_count), 64'd3);

        // Consume in the same cycle as an issue with credits=1
        main_tc = 1'b1;
        tick();
        chk("sim_pre_state", 64'(dut.state_q), S_ISSUE);
        chk("sim_pre_credits", 64'(dut.credits_q), 64'd1);
        tick();
        main_tc = 1'b0;
        chk("sim_ls", 64'(bus.load_start), 64'd1);
        chk("sim_credits", 64'(dut.credits_q), 64'd1);
        chk("sim_base", bases(), 64'({16'd16, 16'd0, 16'd16}));
        run(10);
        chk("ovf_drain_state", 64'(dut.state_q), S_DRAIN);
        chk("ovf_drain_credits", 64'(dut.credits_q), 64'd1);
        chk("ovf_no_done_yet", 64'(done_count), 64'd0);

        // Overflow: extra consume while DRAIN already holds full credits
        main_tc = 1'b1;
        tick();
        chk("ovf_err_before", 64'(bus.err), 64'd0);
        chk("ovf_full_credits", 64'(dut.credits_q), 64'd2);
        tick();
        main_tc = 1'b0;
        chk("ovf_done", 64'(bus.done), 64'd1);
        chk("ovf_err", 64'(bus.err), 64'd1);
        chk("ovf_busy", 64'(bus.busy), 64'd0);
        run(5);
        chk("ovf_err_sticky", 64'(bus.err), 64'd1);
        chk("ovf_done_count", 64'(done_count), 64'd1);
        auto_ld_en = 1'b0;

        // Reset during the second WAIT_LOAD
        clr();
        auto_ld_en = 1'b1;
        auto_tc_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 60 && ls_count < 2; i++) tick();
        chk("mrst_ls2_seen", 64'(ls_count), 64'd2);
        chk("mrst_pre_state", 64'(dut.state_q), S_WAIT);
        auto_ld_en = 1'b0;
        auto_tc_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", 64'(bus.busy), 64'd0);
        chk("mrst_ls", 64'(bus.load_start), 64'd0);
        chk("mrst_ready", 64'(bus.tile_ready), 64'd0);
        chk("mrst_done", 64'(bus.done), 64'd0);
        chk("mrst_err", 64'(bus.err), 64'd0);
        chk("mrst_bases", bases(), 64'd0);
        clr();
        main_ld = 1'b1;
        tick();
        main_ld = 1'b0;
        main_tc = 1'b1;
        tick();
        main_tc = 1'b0;
        run(3);
        chk("mrst_late_ready", 64'(rdy_count), 64'd0);
        chk("mrst_late_done", 64'(done_count), 64'd0);
        chk("mrst_late_credits", 64'(dut.credits_q), 64'd2);
        chk("mrst_late_err", 64'(bus.err), 64'd0);
        chk("mrst_late_busy", 64'(bus.busy), 64'd0);
        pulse_start();
        tick();
        chk("mrst_restart_ls", 64'(bus.load_start), 64'd1);
        chk("mrst_restart_base", bases(), 64'd0);
        pulse_rst();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
